// File: rtl/clk_div_sched.sv
// Run-time programmable clock divider: emits a square wave and a last-cycle tick every N clocks.
// New ratios arrive over valid/ready and only take effect on a period boundary.
module clk_div_sched #(
  parameter int unsigned W           = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic         cfg_valid_i,
  input  logic [W-1:0] cfg_div_i,
  output logic         cfg_ready_o,
  output logic         div_o,
  output logic         tick_o,
  output logic         busy_o,
  output logic         err_o,
  output logic [W-1:0] ratio_o,
  output logic [1:0]   dbg_state_o
);

  // Handshake: a ratio transfers on any cycle where cfg_valid_i && cfg_ready_o;
  // cfg_ready_o depends only on registered state, never on cfg_valid_i.

  if (DEFAULT_DIV < 2 || DEFAULT_DIV > (2 ** W) - 1) begin : g_bad_default
    $error("clk_div_sched: DEFAULT_DIV out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_nxt;
  logic [W-1:0] r_ratio;
  logic [W-1:0] w_ratio_nxt;
  logic [W-1:0] r_pend;
  logic [W-1:0] w_pend_nxt;
  logic         r_err;
  logic         w_err_nxt;

  logic         w_ready;
  logic         w_xfer;
  logic         w_bad;
  logic         w_good;
  logic         w_active;
  logic         w_wrap;

  assign w_ready  = (r_state != ST_PEND);
  assign w_xfer   = cfg_valid_i && w_ready;
  assign w_bad    = w_xfer && (cfg_div_i < W'(2));
  assign w_good   = w_xfer && !w_bad;
  assign w_active = (r_state != ST_IDLE);
  // ratio is always >= 2, so ratio-1 cannot underflow.
  assign w_wrap   = w_active && (r_cnt == r_ratio - W'(1));

  // State register (all sequential state, including the datapath).
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ratio <= W'(DEFAULT_DIV);
      r_pend  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ratio <= w_ratio_nxt;
      r_pend  <= w_pend_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ratio_nxt = r_ratio;
    w_pend_nxt  = r_pend;
    w_err_nxt   = w_bad;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_good) begin
          w_ratio_nxt = cfg_div_i;
        end
        if (en_i) begin
          w_state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        if (w_wrap) begin
          // A ratio arriving in the wrap cycle starts the very next period.
          w_cnt_nxt = '0;
          if (w_good) begin
            w_ratio_nxt = cfg_div_i;
          end
          w_state_nxt = en_i ? ST_RUN : ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + W'(1);
          if (w_good) begin
            w_pend_nxt  = cfg_div_i;
            w_state_nxt = ST_PEND;
          end
        end
      end

      ST_PEND: begin
        if (w_wrap) begin
          w_cnt_nxt   = '0;
          w_ratio_nxt = r_pend;
          w_state_nxt = en_i ? ST_RUN : ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from registers only.
  always_comb begin
    cfg_ready_o = w_ready;
    busy_o      = w_active;
    div_o       = w_active && (r_cnt < (r_ratio >> 1));
    tick_o      = w_wrap;
    err_o       = r_err;
    ratio_o     = r_ratio;
    dbg_state_o = r_state;
  end

endmodule

// File: tb/tb_clk_div_sched.sv
// Bench for clk_div_sched: directed scenarios plus random traffic, checked cycle by cycle
// against a period-position reference model.
module tb_clk_div_sched;

  localparam int W    = 8;
  localparam int DEFN = 4;

  logic         clk = 1'b0;
  logic         rst_n_i;
  logic         en_i;
  logic         cfg_valid_i;
  logic [W-1:0] cfg_div_i;
  logic         cfg_ready_o;
  logic         div_o;
  logic         tick_o;
  logic         busy_o;
  logic         err_o;
  logic [W-1:0] ratio_o;
  logic [1:0]   dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: running flag, position in the current period, active ratio,
  // queue of accepted-but-not-applied ratios, and the pending error pulse.
  bit           m_run;
  int           m_pos;
  int           m_ratio;
  logic [W-1:0] exp_q[$];
  bit           m_err;

  clk_div_sched #(.W(W), .DEFAULT_DIV(DEFN)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .en_i        (en_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_div_i   (cfg_div_i),
    .cfg_ready_o (cfg_ready_o),
    .div_o       (div_o),
    .tick_o      (tick_o),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .ratio_o     (ratio_o),
    .dbg_state_o (dbg_state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update(input logic rst, input logic en, input logic v, input logic [W-1:0] d);
    bit xfer;
    bit bad;
    bit good;
    if (!rst) begin
      m_run   = 0;
      m_pos   = 0;
      m_ratio = DEFN;
      m_err   = 0;
      exp_q.delete();
      return;
    end
    xfer  = v && (exp_q.size() == 0);
    bad   = xfer && (d < 2);
    good  = xfer && !bad;
    m_err = bad;
    if (!m_run) begin
      if (good) m_ratio = d;
      if (en) begin
        m_run = 1;
        m_pos = 0;
      end
    end else if (m_pos == m_ratio - 1) begin
      if (exp_q.size() != 0) m_ratio = exp_q.pop_front();
      else if (good) m_ratio = d;
      m_pos = 0;
      m_run = en;
    end else begin
      m_pos++;
      if (good) exp_q.push_back(d);
    end
  endtask

  task automatic compare_all();
    check("div",   div_o,       m_run && (m_pos < m_ratio / 2));
    check("tick",  tick_o,      m_run && (m_pos == m_ratio - 1));
    check("busy",  busy_o,      m_run);
    check("dbg",   dbg_state_o != 2'd0, m_run);
    check("ready", cfg_ready_o, exp_q.size() == 0);
    check("err",   err_o,       m_err);
    check("ratio", ratio_o,     m_ratio);
  endtask

  // Called at a falling edge: drive, clock, update model, compare at the next falling edge.
  task automatic step(input logic rst, input logic en, input logic v, input logic [W-1:0] d);
    rst_n_i     = rst;
    en_i        = en;
    cfg_valid_i = v;
    cfg_div_i   = d;
    @(posedge clk);
    model_update(rst, en, v, d);
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_pos(input int p);
    int guard = 0;
    while (!(m_run && m_pos == p) && guard < 600) begin
      step(1, 1, 0, 0);
      guard++;
    end
    check("wait_pos_reached", (m_run && m_pos == p), 1);
  endtask

  initial begin
    int nticks;
    rst_n_i     = 1'b0;
    en_i        = 1'b0;
    cfg_valid_i = 1'b0;
    cfg_div_i   = '0;
    @(negedge clk);

    // Reset state.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("rst_ratio", ratio_o, 4);
    check("rst_ready", cfg_ready_o, 1);
    check("rst_busy",  busy_o, 0);
    check("rst_div",   div_o, 0);

    // Enable at cycle 0: div 1,1,0,0 and tick on cycles 4, 8, 12.
    step(1, 1, 0, 0);
    for (int c = 1; c <= 12; c++) begin
      check("tp1_div",  div_o,  (c % 4 == 1) || (c % 4 == 2));
      check("tp1_tick", tick_o, (c % 4 == 0));
      check("tp1_busy", busy_o, 1);
      step(1, 1, 0, 0);
    end

    // Offer 3 at cnt=1: held pending until the wrap.
    wait_pos(1);
    step(1, 1, 1, 3);
    check("tp2_ready_c2", cfg_ready_o, 0);
    step(1, 1, 0, 0);
    check("tp2_ready_c3", cfg_ready_o, 0);
    check("tp2_tick_c3",  tick_o, 1);
    check("tp2_old_ratio", ratio_o, 4);
    step(1, 1, 0, 0);
    check("tp2_new_ratio", ratio_o, 3);
    check("tp2_div0", div_o, 1);
    step(1, 1, 0, 0);
    check("tp2_div1", div_o, 0);
    step(1, 1, 0, 0);
    check("tp2_div2", div_o, 0);
    check("tp2_tick2", tick_o, 1);

    // Back to 4 via a wrap-cycle offer, then bad ratios.
    wait_pos(2);
    step(1, 1, 1, 4);
    check("wrap4_ratio", ratio_o, 4);
    check("wrap4_ready", cfg_ready_o, 1);
    step(1, 1, 1, 1);
    check("bad1_err",   err_o, 1);
    check("bad1_ratio", ratio_o, 4);
    check("bad1_ready", cfg_ready_o, 1);
    step(1, 1, 1, 0);
    check("bad0_err",   err_o, 1);
    check("bad0_ratio", ratio_o, 4);
    step(1, 1, 0, 0);
    check("bad_err_clear", err_o, 0);

    // Offer 6 exactly in the wrap cycle: no pending phase.
    wait_pos(3);
    step(1, 1, 1, 6);
    check("wrap6_ratio", ratio_o, 6);
    check("wrap6_ready", cfg_ready_o, 1);
    for (int k = 0; k < 6; k++) begin
      check("wrap6_div", div_o, k < 3);
      step(1, 1, 0, 0);
    end
    wait_pos(5);
    step(1, 1, 1, 4);

    // Drop en at cnt=1 with 5 pending: period completes, then idle with ratio 5.
    wait_pos(1);
    step(1, 0, 1, 5);
    check("stop_tick_c2", tick_o, 0);
    step(1, 0, 0, 0);
    check("stop_tick_c3", tick_o, 1);
    step(1, 0, 0, 0);
    check("stop_busy",  busy_o, 0);
    check("stop_div",   div_o, 0);
    check("stop_ratio", ratio_o, 5);
    step(1, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      check("restart5_div", div_o, k < 2);
      step(1, 1, 0, 0);
    end

    // Reset while pending at cnt=2 discards the pending ratio.
    wait_pos(1);
    step(1, 1, 1, 7);
    check("pend_ready", cfg_ready_o, 0);
    step(0, 1, 0, 0);
    check("prst_ratio", ratio_o, 4);
    check("prst_div",   div_o, 0);
    check("prst_ready", cfg_ready_o, 1);
    check("prst_busy",  busy_o, 0);
    step(1, 0, 0, 0);
    check("prst_lost", ratio_o, 4);

    // Maximum ratio, started together with the enabling edge.
    step(1, 1, 1, 255);
    nticks = 0;
    for (int i = 1; i <= 510; i++) begin
      if (tick_o) nticks++;
      step(1, 1, 0, 0);
    end
    check("max_ticks", nticks, 2);
    check("max_ratio", ratio_o, 255);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic         r;
      logic         e;
      logic         v;
      logic [W-1:0] d;
      r = ($urandom_range(0, 199) != 0);
      e = ($urandom_range(0, 9) != 0);
      v = ($urandom_range(0, 4) == 0);
      d = ($urandom_range(0, 19) == 0) ? W'($urandom_range(100, 255)) : W'($urandom_range(0, 12));
      step(r, e, v, d);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
